// File: rtl/riscv_core_dpath_vec_regfile_param_pkg.sv
// Shared defaults and types for the parametrised vector register file.
package riscv_core_dpath_vec_regfile_param_pkg;

  localparam int DEF_NREGS  = 32;
  localparam int DEF_NELEMS = 8;
  localparam int DEF_ELEM_W = 32;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/riscv_vec_elem_wmask.sv
// Effective per-element write enable; shared by the array write and the bypass merge.
module riscv_vec_elem_wmask #(
  parameter int NELEMS = 8,
  parameter int AW     = 5,
  parameter int VLW    = 4
) (
  input  logic              wen,
  input  logic              busy,
  input  logic [AW-1:0]     waddr,
  input  logic [NELEMS-1:0] wmask,
  input  logic [VLW-1:0]    vl,
  output logic [NELEMS-1:0] elem_en
);

  logic write_ok;
  assign write_ok = wen && !busy && (waddr != '0);

  // Tail elements at or beyond vl are never written.
  for (genvar gi = 0; gi < NELEMS; gi++) begin : g_en
    assign elem_en[gi] = write_ok && wmask[gi] && (VLW'(gi) < vl);
  end

endmodule

// File: rtl/riscv_core_dpath_vec_regfile_param.sv
// Vector register file: two combinational read ports, one element-masked write port,
// vector-length register and a post-reset zeroing sweep.
module riscv_core_dpath_vec_regfile_param
  import riscv_core_dpath_vec_regfile_param_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int NELEMS = DEF_NELEMS,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int BYPASS = 0,
  localparam int AW    = $clog2(NREGS),
  localparam int VLW   = $clog2(NELEMS) + 1,
  localparam int VW    = NELEMS * ELEM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     raddr0,
  output logic [VW-1:0]     rdata0,
  input  logic [AW-1:0]     raddr1,
  output logic [VW-1:0]     rdata1,
  input  logic              wen_p,
  input  logic [AW-1:0]     waddr_p,
  input  logic [VW-1:0]     wdata_p,
  input  logic [NELEMS-1:0] wmask_p,
  input  logic              wvlen_p,
  input  logic [31:0]       wvl_p,
  output logic [VLW-1:0]    vl,
  output logic              busy
);

  rf_state_e         state_reg, state_next;
  logic [AW-1:0]     cnt_reg, cnt_next;
  logic [VLW-1:0]    vl_reg, vl_next;
  logic [NELEMS-1:0] elem_en;
  logic [VW-1:0]     regs_reg [NREGS];
  logic [VW-1:0]     stored0, stored1;

  assign busy = (state_reg == ST_INIT);
  assign vl   = vl_reg;

  riscv_vec_elem_wmask #(
    .NELEMS (NELEMS),
    .AW     (AW),
    .VLW    (VLW)
  ) u_wmask (
    .wen     (wen_p),
    .busy    (busy),
    .waddr   (waddr_p),
    .wmask   (wmask_p),
    .vl      (vl_reg),
    .elem_en (elem_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
      vl_reg    <= VLW'(NELEMS);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      vl_reg    <= vl_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    vl_next    = vl_reg;
    case (state_reg)
      ST_INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == AW'(NREGS - 1)) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        // Full 32-bit compare so large requests clamp instead of wrapping.
        if (wvlen_p) begin
          vl_next = (wvl_p >= 32'(NELEMS)) ? VLW'(NELEMS) : wvl_p[VLW-1:0];
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // A write in a reset cycle is harmless: the sweep that follows clears every register.
  always_ff @(posedge clk) begin
    if (state_reg == ST_INIT) begin
      regs_reg[cnt_reg] <= '0;
    end else begin
      for (int i = 0; i < NELEMS; i++) begin
        if (elem_en[i]) begin
          regs_reg[waddr_p][i*ELEM_W +: ELEM_W] <= wdata_p[i*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  assign stored0 = regs_reg[raddr0];
  assign stored1 = regs_reg[raddr1];

  for (genvar gi = 0; gi < NELEMS; gi++) begin : g_rd
    logic byp0, byp1;
    assign byp0 = (BYPASS != 0) && (raddr0 == waddr_p) && elem_en[gi];
    assign byp1 = (BYPASS != 0) && (raddr1 == waddr_p) && elem_en[gi];

    assign rdata0[gi*ELEM_W +: ELEM_W] = (busy || raddr0 == '0) ? '0 :
                                         byp0 ? wdata_p[gi*ELEM_W +: ELEM_W] :
                                                stored0[gi*ELEM_W +: ELEM_W];
    assign rdata1[gi*ELEM_W +: ELEM_W] = (busy || raddr1 == '0) ? '0 :
                                         byp1 ? wdata_p[gi*ELEM_W +: ELEM_W] :
                                                stored1[gi*ELEM_W +: ELEM_W];
  end

endmodule

// File: tb/tb_riscv_core_dpath_vec_regfile_param.sv
// Bench for the vector register file: directed cases plus random traffic against a behavioural model.
module tb_riscv_core_dpath_vec_regfile_param;

  localparam int NREGS  = 32;
  localparam int NELEMS = 8;
  localparam int ELEM_W = 32;
  localparam int AW     = 5;
  localparam int VLW    = 4;
  localparam int VW     = NELEMS * ELEM_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     raddr0, raddr1, waddr_p;
  logic              wen_p, wvlen_p;
  logic [VW-1:0]     wdata_p;
  logic [NELEMS-1:0] wmask_p;
  logic [31:0]       wvl_p;

  logic [VW-1:0]  rdata0_b0, rdata1_b0, rdata0_b1, rdata1_b1;
  logic [VLW-1:0] vl_b0, vl_b1;
  logic           busy_b0, busy_b1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: element-level storage, vl as an integer, busy as a countdown.
  logic [ELEM_W-1:0] mem_m [NREGS][NELEMS];
  int unsigned       vl_m;
  int                busy_left_m;

  always #5 clk = ~clk;

  riscv_core_dpath_vec_regfile_param #(.BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .raddr0(raddr0), .rdata0(rdata0_b0),
    .raddr1(raddr1), .rdata1(rdata1_b0), .wen_p(wen_p), .waddr_p(waddr_p),
    .wdata_p(wdata_p), .wmask_p(wmask_p), .wvlen_p(wvlen_p), .wvl_p(wvl_p),
    .vl(vl_b0), .busy(busy_b0)
  );

  riscv_core_dpath_vec_regfile_param #(.BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .raddr0(raddr0), .rdata0(rdata0_b1),
    .raddr1(raddr1), .rdata1(rdata1_b1), .wen_p(wen_p), .waddr_p(waddr_p),
    .wdata_p(wdata_p), .wmask_p(wmask_p), .wvlen_p(wvlen_p), .wvl_p(wvl_p),
    .vl(vl_b1), .busy(busy_b1)
  );

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] model_read(input int addr, input bit byp);
    logic [VW-1:0] r;
    logic [ELEM_W-1:0] e;
    r = '0;
    if (busy_left_m > 0 || addr == 0) return r;
    for (int i = 0; i < NELEMS; i++) begin
      e = mem_m[addr][i];
      if (byp && wen_p && addr == int'(waddr_p) && waddr_p != 0 && i < vl_m && wmask_p[i])
        e = wdata_p[i*ELEM_W +: ELEM_W];
      r[i*ELEM_W +: ELEM_W] = e;
    end
    return r;
  endfunction

  task automatic model_update();
    if (reset) begin
      vl_m        = NELEMS;
      busy_left_m = NREGS;
      for (int r = 0; r < NREGS; r++)
        for (int i = 0; i < NELEMS; i++) mem_m[r][i] = '0;
    end else if (busy_left_m > 0) begin
      busy_left_m--;
    end else begin
      if (wen_p && waddr_p != 0)
        for (int i = 0; i < NELEMS; i++)
          if (i < vl_m && wmask_p[i]) mem_m[waddr_p][i] = wdata_p[i*ELEM_W +: ELEM_W];
      if (wvlen_p) vl_m = (wvl_p >= NELEMS) ? NELEMS : wvl_p;
    end
  endtask

  // Inputs are driven at posedge+1; outputs are checked at posedge+4, then the edge is taken.
  task automatic cycle();
    #3;
    check("busy0", VW'(busy_b0), VW'(busy_left_m > 0));
    check("busy1", VW'(busy_b1), VW'(busy_left_m > 0));
    check("vl0", VW'(vl_b0), VW'(vl_m));
    check("vl1", VW'(vl_b1), VW'(vl_m));
    check("rd0_nobyp", rdata0_b0, model_read(raddr0, 0));
    check("rd1_nobyp", rdata1_b0, model_read(raddr1, 0));
    check("rd0_byp", rdata0_b1, model_read(raddr0, 1));
    check("rd1_byp", rdata1_b1, model_read(raddr1, 1));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    reset = 0; wen_p = 0; wvlen_p = 0; wvl_p = '0; waddr_p = '0;
    wdata_p = '0; wmask_p = '0;
  endtask

  task automatic set_vl(input logic [31:0] v);
    wvlen_p = 1; wvl_p = v;
    cycle();
    wvlen_p = 0;
  endtask

  function automatic logic [VW-1:0] splat(input logic [ELEM_W-1:0] val, input int n);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*ELEM_W +: ELEM_W] = val;
    return r;
  endfunction

  initial begin
    int cnt;
    logic [31:0] clamp_in [4];
    int          clamp_exp [4];
    logic [VW-1:0] exp_v;

    idle();
    raddr0 = '0; raddr1 = '0;
    reset = 1;
    @(posedge clk);
    model_update();
    #1;
    cycle();
    $display("[TB] txn reset: busy=%0d vl=%0d", busy_b0, vl_b0);
    check("reset_vl", VW'(vl_b0), VW'(NELEMS));

    // Sweep length and reads of every address while busy.
    reset = 0; cnt = 0;
    while (busy_b0 && cnt < 100) begin
      raddr0 = AW'(cnt); raddr1 = AW'(NREGS - 1 - cnt);
      cycle();
      cnt++;
    end
    $display("[TB] txn sweep: busy cycles=%0d", cnt);
    check("sweep_len", VW'(cnt), VW'(NREGS));
    for (int a = 0; a < NREGS; a++) begin
      raddr0 = AW'(a); raddr1 = AW'(a);
      cycle();
      check("post_sweep_zero", rdata0_b0, '0);
    end

    // vl clamping.
    clamp_in[0] = 32'd20; clamp_in[1] = 32'd5; clamp_in[2] = 32'd0; clamp_in[3] = 32'h8000_0003;
    clamp_exp[0] = 8;     clamp_exp[1] = 5;    clamp_exp[2] = 0;    clamp_exp[3] = 8;
    for (int k = 0; k < 4; k++) begin
      set_vl(clamp_in[k]);
      $display("[TB] txn vl_clamp: wvl=%h vl=%0d", clamp_in[k], vl_b0);
      check("vl_clamp", VW'(vl_b0), VW'(clamp_exp[k]));
    end

    // Tail handling with vl=3.
    set_vl(32'd3);
    wen_p = 1; waddr_p = 5; wmask_p = 8'hFF; wdata_p = splat(32'hA5A5_A5A5, NELEMS);
    cycle();
    idle(); raddr0 = 5;
    #1;
    $display("[TB] txn tail_vl3: r5=%h", rdata0_b0);
    check("tail_vl3", rdata0_b0, splat(32'hA5A5_A5A5, 3));
    cycle();

    // Same-cycle vl update does not affect the concurrent write.
    set_vl(32'd2);
    wvlen_p = 1; wvl_p = 8; wen_p = 1; waddr_p = 7; wmask_p = 8'hFF;
    wdata_p = splat(32'h1234_5678, NELEMS);
    cycle();
    idle(); raddr1 = 7;
    #1;
    $display("[TB] txn vl_same_cycle: vl=%0d r7=%h", vl_b0, rdata1_b0);
    check("vl_after", VW'(vl_b0), VW'(8));
    check("r7_two_elems", rdata1_b0, splat(32'h1234_5678, 2));
    cycle();

    // Register 0 ignores writes.
    wen_p = 1; waddr_p = 0; wmask_p = 8'hFF; wdata_p = '1;
    cycle();
    idle(); raddr0 = 0;
    #1;
    check("r0_zero", rdata0_b0, '0);
    cycle();

    // Same-cycle bypass on r9, low four elements.
    wen_p = 1; waddr_p = 9; wmask_p = 8'h0F; raddr0 = 9;
    for (int i = 0; i < NELEMS; i++) wdata_p[i*ELEM_W +: ELEM_W] = 32'hCAFE_0000 + 32'(i);
    exp_v = '0;
    for (int i = 0; i < 4; i++) exp_v[i*ELEM_W +: ELEM_W] = 32'hCAFE_0000 + 32'(i);
    #1;
    $display("[TB] txn bypass: byp=%h", rdata0_b1);
    check("bypass_on", rdata0_b1, exp_v);
    check("bypass_off", rdata0_b0, '0);
    cycle();
    idle();
    cycle();

    // Reset mid-sweep, with writes and vl updates pulsed while busy.
    set_vl(32'd4);
    reset = 1; cycle(); reset = 0;
    for (int c = 0; c < 10; c++) cycle();
    reset = 1; cycle(); reset = 0;
    wen_p = 1; waddr_p = 4; wmask_p = 8'hFF; wdata_p = '1; wvlen_p = 1; wvl_p = 3;
    raddr0 = 4; cnt = 0;
    while (busy_b0 && cnt < 100) begin
      cycle();
      cnt++;
    end
    idle();
    #1;
    $display("[TB] txn reset_mid_sweep: busy cycles=%0d vl=%0d", cnt, vl_b0);
    check("resweep_len", VW'(cnt), VW'(NREGS));
    check("resweep_vl", VW'(vl_b0), VW'(NELEMS));
    check("resweep_r4", rdata0_b0, '0);
    cycle();

    // Random traffic.
    for (int t = 0; t < 600; t++) begin
      reset   = ($urandom_range(0, 299) == 0);
      wen_p   = ($urandom_range(0, 3) != 0);
      waddr_p = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wmask_p = NELEMS'($urandom);
      for (int i = 0; i < NELEMS; i++) wdata_p[i*ELEM_W +: ELEM_W] = $urandom;
      wvlen_p = ($urandom_range(0, 7) == 0);
      wvl_p   = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 10));
      raddr0  = ($urandom_range(0, 2) == 0) ? waddr_p : AW'($urandom_range(0, 3));
      raddr1  = ($urandom_range(0, 2) == 0) ? waddr_p : AW'($urandom);
      $display("[TB] txn rnd %0d: rst=%0d wen=%0d wa=%0d m=%h vlen=%0d wvl=%h ra0=%0d ra1=%0d",
               t, reset, wen_p, waddr_p, wmask_p, wvlen_p, wvl_p, raddr0, raddr1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
